// File: rtl/ball_motion_engine_if.sv
// Handshake/bus bundle between the ball engine, the paddle/collision
// side (inputs) and the renderer/score keeper side (outputs).
interface ball_motion_engine_if #(
    parameter int FIELD_W = 64,
    parameter int FIELD_H = 48
);
    localparam int XIW = $clog2(FIELD_W);
    localparam int YIW = $clog2(FIELD_H);

    logic           tick;
    logic           start;
    logic [YIW-1:0] paddle_l_y;
    logic [YIW-1:0] paddle_r_y;
    logic [XIW-1:0] ball_x;
    logic [YIW-1:0] ball_y;
    logic           dir_x;
    logic           dir_y;
    logic           score_l;
    logic           score_r;
    logic           in_play;
    logic [1:0]     state_o;

    modport master (
        output tick, start, paddle_l_y, paddle_r_y,
        input  ball_x, ball_y, dir_x, dir_y, score_l, score_r, in_play, state_o
    );

    modport slave (
        input  tick, start, paddle_l_y, paddle_r_y,
        output ball_x, ball_y, dir_x, dir_y, score_l, score_r, in_play, state_o
    );
endinterface

// File: rtl/ball_motion_engine.sv
// Pong ball engine: unsigned fixed-point position and velocity magnitudes,
// centre serve with LFSR-chosen angle, wall reflection, zone-dependent
// paddle bounces with speed-up, miss detection and delayed re-serve.
module ball_motion_engine #(
    parameter int FIELD_W     = 64,
    parameter int FIELD_H     = 48,
    parameter int FRAC_W      = 4,
    parameter int PADDLE_H    = 8,
    parameter int PADDLE_L_X  = 2,
    parameter int PADDLE_R_X  = 61,
    parameter int VX_INIT     = 16,
    parameter int VX_STEP     = 4,
    parameter int VX_MAX      = 48,
    parameter int SERVE_DELAY = 30
) (
    input  logic                clk,
    input  logic                reset,
    ball_motion_engine_if.slave bus
);
    localparam int XIW  = $clog2(FIELD_W);
    localparam int YIW  = $clog2(FIELD_H);
    localparam int XW   = XIW + FRAC_W;
    localparam int YW   = YIW + FRAC_W;
    localparam int CW   = ((XIW > YIW) ? XIW : YIW) + FRAC_W + 2;
    localparam int VW   = CW - 1;
    localparam int PW   = YIW + 2;
    localparam int CNTW = $clog2(SERVE_DELAY + 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WAIT   = 2'd1,
        S_MOVING = 2'd2,
        S_SCORED = 2'd3
    } state_t;

    localparam logic [XW-1:0]        X_CENTRE = XW'((FIELD_W / 2) << FRAC_W);
    localparam logic [YW-1:0]        Y_CENTRE = YW'((FIELD_H / 2) << FRAC_W);
    localparam logic [XW-1:0]        X_L_HIT  = XW'((PADDLE_L_X + 1) << FRAC_W);
    localparam logic [XW-1:0]        X_R_HIT  = XW'((PADDLE_R_X - 1) << FRAC_W);
    // int(nx) <= PADDLE_L_X  <=>  nx < (PADDLE_L_X+1) << FRAC_W (floor semantics)
    localparam logic signed [CW-1:0] C_L_EDGE = CW'((PADDLE_L_X + 1) << FRAC_W);
    localparam logic signed [CW-1:0] C_R_EDGE = CW'(PADDLE_R_X << FRAC_W);
    localparam logic signed [CW-1:0] C_X_MAX  = CW'((FIELD_W - 1) << FRAC_W);
    localparam logic signed [CW-1:0] C_Y_MAX  = CW'((FIELD_H - 1) << FRAC_W);
    localparam logic [VW-1:0]        V_INIT   = VW'(VX_INIT);
    localparam logic [VW-1:0]        V_STEP   = VW'(VX_STEP);
    localparam logic [VW-1:0]        V_MAX    = VW'(VX_MAX);
    localparam logic [VW-1:0]        V_ZONE   = VW'(12);
    localparam logic [PW-1:0]        P_SPAN   = PW'(PADDLE_H - 1);
    localparam logic [PW-1:0]        Z_TOP    = PW'(PADDLE_H / 4);
    localparam logic [PW-1:0]        Z_BOT    = PW'((3 * PADDLE_H) / 4);
    localparam logic [CNTW-1:0]      CNT_LAST = CNTW'(SERVE_DELAY - 1);

    // x^8+x^6+x^5+x^4+1 Fibonacci step
    function automatic logic [7:0] lfsr_next(input logic [7:0] s);
        return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
    endfunction

    state_t          r_state;
    logic [XW-1:0]   r_x;
    logic [YW-1:0]   r_y;
    logic [VW-1:0]   r_vx;
    logic [VW-1:0]   r_vy;
    logic            r_dir_x;
    logic            r_dir_y;
    logic            r_score_l;
    logic            r_score_r;
    logic            r_in_play;
    logic [7:0]      r_lfsr;
    logic [CNTW-1:0] r_cnt;
    logic            r_first;
    logic            r_serve_dir;

    logic signed [CW-1:0] w_sx, w_sy, w_svx, w_svy, w_nx, w_ny;
    logic [PW-1:0]        w_y_int, w_pl_top, w_pr_top, w_off_l, w_off_r;
    logic                 w_at_l, w_at_r, w_hit_l, w_hit_r;
    logic [VW-1:0]        w_vx_sum, w_vx_bump;
    logic [XW-1:0]        w_mv_x;
    logic [YW-1:0]        w_mv_y;
    logic [VW-1:0]        w_mv_vx, w_mv_vy;
    logic                 w_mv_dx, w_mv_dy, w_miss_l, w_miss_r;

    assign w_sx  = $signed({{(CW - XW){1'b0}}, r_x});
    assign w_sy  = $signed({{(CW - YW){1'b0}}, r_y});
    assign w_svx = $signed({1'b0, r_vx});
    assign w_svy = $signed({1'b0, r_vy});

    // Candidate next position along the current direction of travel
    always_comb begin
        w_nx = w_sx;
        w_ny = w_sy;
        if (r_dir_x) begin
            w_nx = w_sx + w_svx;
        end else begin
            w_nx = w_sx - w_svx;
        end
        if (r_dir_y) begin
            w_ny = w_sy + w_svy;
        end else begin
            w_ny = w_sy - w_svy;
        end
    end

    // Paddle windows are judged on the pre-update integer row
    assign w_y_int  = {2'b00, r_y[YW-1:FRAC_W]};
    assign w_pl_top = {2'b00, bus.paddle_l_y};
    assign w_pr_top = {2'b00, bus.paddle_r_y};
    assign w_hit_l  = (w_y_int >= w_pl_top) && (w_y_int <= w_pl_top + P_SPAN);
    assign w_hit_r  = (w_y_int >= w_pr_top) && (w_y_int <= w_pr_top + P_SPAN);
    assign w_off_l  = w_y_int - w_pl_top;
    assign w_off_r  = w_y_int - w_pr_top;
    assign w_at_l   = !r_dir_x && (w_nx < C_L_EDGE);
    assign w_at_r   = r_dir_x && (w_nx >= C_R_EDGE);
    assign w_vx_sum = r_vx + V_STEP;

    // Speed-up on paddle contact, saturated at VX_MAX
    always_comb begin
        w_vx_bump = w_vx_sum;
        if (w_vx_sum > V_MAX) begin
            w_vx_bump = V_MAX;
        end else begin
            w_vx_bump = w_vx_sum;
        end
    end

    // One MOVING step: wall clamp first, then paddle contact / miss
    always_comb begin
        w_mv_x   = w_nx[XW-1:0];
        w_mv_y   = w_ny[YW-1:0];
        w_mv_vx  = r_vx;
        w_mv_vy  = r_vy;
        w_mv_dx  = r_dir_x;
        w_mv_dy  = r_dir_y;
        w_miss_l = 1'b0;
        w_miss_r = 1'b0;
        if (w_ny[CW-1]) begin
            w_mv_y  = '0;
            w_mv_dy = 1'b1;
        end else if (w_ny > C_Y_MAX) begin
            w_mv_y  = C_Y_MAX[YW-1:0];
            w_mv_dy = 1'b0;
        end else begin
            w_mv_y  = w_ny[YW-1:0];
        end
        if (w_at_l) begin
            if (w_hit_l) begin
                w_mv_x  = X_L_HIT;
                w_mv_dx = 1'b1;
                w_mv_vx = w_vx_bump;
                if (w_off_l < Z_TOP) begin
                    w_mv_dy = 1'b0;
                    w_mv_vy = V_ZONE;
                end else if (w_off_l >= Z_BOT) begin
                    w_mv_dy = 1'b1;
                    w_mv_vy = V_ZONE;
                end else begin
                    w_mv_vy = r_vy;
                end
            end else if (w_nx[CW-1]) begin
                w_mv_x   = r_x;
                w_miss_l = 1'b1;
            end else begin
                w_mv_x = w_nx[XW-1:0];
            end
        end else if (w_at_r) begin
            if (w_hit_r) begin
                w_mv_x  = X_R_HIT;
                w_mv_dx = 1'b0;
                w_mv_vx = w_vx_bump;
                if (w_off_r < Z_TOP) begin
                    w_mv_dy = 1'b0;
                    w_mv_vy = V_ZONE;
                end else if (w_off_r >= Z_BOT) begin
                    w_mv_dy = 1'b1;
                    w_mv_vy = V_ZONE;
                end else begin
                    w_mv_vy = r_vy;
                end
            end else if (w_nx > C_X_MAX) begin
                w_mv_x   = r_x;
                w_miss_r = 1'b1;
            end else begin
                w_mv_x = w_nx[XW-1:0];
            end
        end else begin
            w_mv_x = w_nx[XW-1:0];
        end
    end

    // Game FSM with registered ball state, pulses and LFSR
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_x         <= X_CENTRE;
            r_y         <= Y_CENTRE;
            r_vx        <= V_INIT;
            r_vy        <= '0;
            r_dir_x     <= 1'b0;
            r_dir_y     <= 1'b0;
            r_score_l   <= 1'b0;
            r_score_r   <= 1'b0;
            r_in_play   <= 1'b0;
            r_lfsr      <= 8'hA5;
            r_cnt       <= '0;
            r_first     <= 1'b1;
            r_serve_dir <= 1'b0;
        end else begin
            r_lfsr    <= lfsr_next(r_lfsr);
            r_score_l <= 1'b0;
            r_score_r <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_x <= X_CENTRE;
                    r_y <= Y_CENTRE;
                    if (bus.start) begin
                        r_state <= S_WAIT;
                        r_cnt   <= '0;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_WAIT: begin
                    if (bus.tick) begin
                        if (r_cnt == CNT_LAST) begin
                            r_state   <= S_MOVING;
                            r_in_play <= 1'b1;
                            r_vx      <= V_INIT;
                            r_vy      <= VW'({r_lfsr[1:0], 2'b00}) + VW'(4);
                            r_dir_y   <= r_lfsr[2];
                            r_dir_x   <= r_first ? r_lfsr[3] : r_serve_dir;
                            r_first   <= 1'b0;
                        end else begin
                            r_cnt <= r_cnt + CNTW'(1);
                        end
                    end else begin
                        r_state <= S_WAIT;
                    end
                end
                S_MOVING: begin
                    if (bus.tick) begin
                        r_x     <= w_mv_x;
                        r_y     <= w_mv_y;
                        r_vx    <= w_mv_vx;
                        r_vy    <= w_mv_vy;
                        r_dir_x <= w_mv_dx;
                        r_dir_y <= w_mv_dy;
                        if (w_miss_l) begin
                            r_score_r   <= 1'b1;
                            r_serve_dir <= 1'b0;
                            r_state     <= S_SCORED;
                            r_in_play   <= 1'b0;
                        end else if (w_miss_r) begin
                            r_score_l   <= 1'b1;
                            r_serve_dir <= 1'b1;
                            r_state     <= S_SCORED;
                            r_in_play   <= 1'b0;
                        end else begin
                            r_state <= S_MOVING;
                        end
                    end else begin
                        r_state <= S_MOVING;
                    end
                end
                S_SCORED: begin
                    r_x     <= X_CENTRE;
                    r_y     <= Y_CENTRE;
                    r_cnt   <= '0;
                    r_state <= S_WAIT;
                end
                default: begin
                    r_state   <= S_IDLE;
                    r_in_play <= 1'b0;
                end
            endcase
        end
    end

    assign bus.ball_x  = r_x[XW-1:FRAC_W];
    assign bus.ball_y  = r_y[YW-1:FRAC_W];
    assign bus.dir_x   = r_dir_x;
    assign bus.dir_y   = r_dir_y;
    assign bus.score_l = r_score_l;
    assign bus.score_r = r_score_r;
    assign bus.in_play = r_in_play;
    assign bus.state_o = r_state;
endmodule

// File: tb/tb_ball_motion_engine.sv
// Randomised bench for ball_motion_engine against an integer game model.
module tb_ball_motion_engine;
    logic clk = 1'b0;
    logic reset;

    ball_motion_engine_if #(.FIELD_W(64), .FIELD_H(48)) bus ();
    ball_motion_engine dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // Model: positions and speeds in 1/16 px, state 0..3 = IDLE/WAIT/MOVING/SCORED
    int m_state, m_x, m_y, m_vx, m_vy, m_dx, m_dy, m_sl, m_sr;
    int m_lfsr, m_cnt, m_first, m_serve_dir;

    function automatic int fl16(input int v);
        return (v >= 0) ? v / 16 : -((-v + 15) / 16);
    endfunction

    function automatic logic [18:0] exp_vec();
        logic [1:0] st;
        st = 2'(m_state);
        return {6'(m_x / 16), 6'(m_y / 16), m_dx[0], m_dy[0], m_sl[0], m_sr[0],
                (m_state == 2), st};
    endfunction

    function automatic logic [18:0] obs_vec();
        return {bus.ball_x, bus.ball_y, bus.dir_x, bus.dir_y, bus.score_l,
                bus.score_r, bus.in_play, bus.state_o};
    endfunction

    task automatic model_reset();
        m_state = 0; m_x = 32 * 16; m_y = 24 * 16; m_vx = 16; m_vy = 0;
        m_dx = 0; m_dy = 0; m_sl = 0; m_sr = 0; m_lfsr = 8'hA5; m_cnt = 0;
        m_first = 1; m_serve_dir = 0;
    endtask

    // Paddle bounce shared by both sides: off is the row offset into the paddle
    task automatic model_zone(input int off);
        m_vx = (m_vx + 4 > 48) ? 48 : m_vx + 4;
        if (off < 2) begin m_dy = 0; m_vy = 12; end
        else if (off >= 6) begin m_dy = 1; m_vy = 12; end
    endtask

    task automatic model_step();
        int cur, nx, ny, yi, pl, pr;
        cur = m_lfsr;
        m_lfsr = ((m_lfsr << 1) | ($countones(m_lfsr & 8'hB8) % 2)) & 8'hFF;
        m_sl = 0; m_sr = 0;
        pl = int'(bus.paddle_l_y); pr = int'(bus.paddle_r_y);
        case (m_state)
            0: begin
                m_x = 32 * 16; m_y = 24 * 16;
                if (bus.start) begin m_state = 1; m_cnt = 0; end
            end
            1: if (bus.tick) begin
                m_cnt++;
                if (m_cnt == 30) begin
                    m_state = 2; m_vx = 16; m_vy = ((cur % 4) + 1) * 4;
                    m_dy = (cur >> 2) & 1;
                    m_dx = m_first ? ((cur >> 3) & 1) : m_serve_dir;
                    m_first = 0;
                end
            end
            2: if (bus.tick) begin
                nx = m_x + (m_dx ? m_vx : -m_vx);
                ny = m_y + (m_dy ? m_vy : -m_vy);
                yi = m_y / 16;
                if (ny < 0) begin m_y = 0; m_dy = 1; end
                else if (ny > 47 * 16) begin m_y = 47 * 16; m_dy = 0; end
                else m_y = ny;
                if (m_dx == 0 && fl16(nx) <= 2) begin
                    if (yi >= pl && yi <= pl + 7) begin
                        m_x = 3 * 16; m_dx = 1; model_zone(yi - pl);
                    end else if (nx < 0) begin
                        m_sr = 1; m_state = 3; m_serve_dir = 0;
                    end else m_x = nx;
                end else if (m_dx == 1 && fl16(nx) >= 61) begin
                    if (yi >= pr && yi <= pr + 7) begin
                        m_x = 60 * 16; m_dx = 0; model_zone(yi - pr);
                    end else if (nx > 63 * 16) begin
                        m_sl = 1; m_state = 3; m_serve_dir = 1;
                    end else m_x = nx;
                end else m_x = nx;
            end
            3: begin m_x = 32 * 16; m_y = 24 * 16; m_cnt = 0; m_state = 1; end
            default: m_state = 0;
        endcase
    endtask

    task automatic step(input logic t, input logic s);
        bus.tick = t; bus.start = s;
        @(posedge clk);
        model_step();
        #1;
        bus.tick = 1'b0; bus.start = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; bus.tick = 1'b0; bus.start = 1'b0;
        bus.paddle_l_y = 6'd0; bus.paddle_r_y = 6'd0;
        model_reset();
        @(posedge clk); #1;
        n_cmp++;
        if (obs_vec() !== exp_vec()) begin
            n_fail++; $display("FAIL reset_hold: got %h want %h", obs_vec(), exp_vec());
        end
        @(negedge clk); reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b0);
            n_cmp++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++; $display("FAIL reset_idle %0d: got %h want %h", i, obs_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_serve();
        int ticks;
        logic t;
        bus.paddle_l_y = 6'd20; bus.paddle_r_y = 6'd20;
        step(1'b0, 1'b1);
        n_cmp++;
        if (obs_vec() !== exp_vec()) begin
            n_fail++; $display("FAIL serve_start: got %h want %h", obs_vec(), exp_vec());
        end
        ticks = 0;
        while (ticks < 30) begin
            t = ($urandom_range(0, 3) != 0);
            step(t, 1'b0);
            if (t) ticks++;
            n_cmp++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++; $display("FAIL serve_wait tick %0d: got %h want %h", ticks, obs_vec(), exp_vec());
            end
        end
        n_cmp++;
        if (bus.state_o !== 2'd2) begin
            n_fail++; $display("FAIL serve_state: got %0d want 2", bus.state_o);
        end
        step(1'b1, 1'b0);
        n_cmp++;
        if (obs_vec() !== exp_vec() || !(bus.ball_x == 6'd31 || bus.ball_x == 6'd33)) begin
            n_fail++; $display("FAIL serve_first_move: got %h want %h", obs_vec(), exp_vec());
        end
    endtask

    // Paddles follow the ball so every approach is a hit, exercising all zones and saturation
    task automatic test_rally();
        int pl, pr;
        for (int i = 0; i < 1500; i++) begin
            pl = m_y / 16 - int'($urandom_range(0, 7)); if (pl < 0) pl = 0;
            pr = m_y / 16 - int'($urandom_range(0, 7)); if (pr < 0) pr = 0;
            bus.paddle_l_y = 6'(pl); bus.paddle_r_y = 6'(pr);
            step($urandom_range(0, 3) != 0, 1'b0);
            n_cmp++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++; $display("FAIL rally cyc %0d: got %h want %h", i, obs_vec(), exp_vec());
            end
        end
    endtask

    // Paddles kept away from the ball so it misses, scores and re-serves
    task automatic test_miss();
        int dut_pulses = 0;
        int mdl_pulses = 0;
        for (int i = 0; i < 800; i++) begin
            bus.paddle_l_y = (m_y / 16 < 24) ? 6'd40 : 6'd0;
            bus.paddle_r_y = (m_y / 16 < 24) ? 6'd40 : 6'd0;
            step(1'b1, 1'b0);
            if (bus.score_l === 1'b1 || bus.score_r === 1'b1) dut_pulses++;
            if (m_sl != 0 || m_sr != 0) mdl_pulses++;
            n_cmp++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++; $display("FAIL miss cyc %0d: got %h want %h", i, obs_vec(), exp_vec());
            end
        end
        n_cmp++;
        if (dut_pulses !== mdl_pulses || mdl_pulses == 0) begin
            n_fail++; $display("FAIL miss_pulses: got %0d want %0d (nonzero)", dut_pulses, mdl_pulses);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 1500; i++) begin
            bus.paddle_l_y = 6'($urandom_range(0, 47));
            bus.paddle_r_y = 6'($urandom_range(0, 47));
            step(1'b1, $urandom_range(0, 15) == 0);
            n_cmp++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++; $display("FAIL b2b cyc %0d: got %h want %h", i, obs_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_reset_mid_move();
        int guard = 0;
        while (m_state != 2 && guard < 200) begin
            step(1'b1, 1'b0);
            guard++;
        end
        n_cmp++;
        if (m_state != 2 || bus.state_o !== 2'd2) begin
            n_fail++; $display("FAIL midrst_reach: got %0d want 2", bus.state_o);
        end
        #2 reset = 1'b1;
        model_reset();
        #1;
        n_cmp++;
        if (obs_vec() !== exp_vec()) begin
            n_fail++; $display("FAIL midrst_async: got %h want %h", obs_vec(), exp_vec());
        end
        @(negedge clk); reset = 1'b0;
        step(1'b1, 1'b0);
        n_cmp++;
        if (obs_vec() !== exp_vec()) begin
            n_fail++; $display("FAIL midrst_release: got %h want %h", obs_vec(), exp_vec());
        end
    endtask

    initial begin
        test_reset();
        test_serve();
        test_rally();
        test_miss();
        test_back_to_back();
        test_reset_mid_move();
        test_serve();
        test_miss();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/ball_motion_engine.md
Name: ball_motion_engine

Overview:
Parametrised Pong ball engine that replaces the single-speed ball mover. It holds ball position and velocity in unsigned fixed point and advances one step per frame `tick`. It serves from field centre with a pseudo-random angle, reflects off top and bottom walls, and bounces off both paddles with zone-dependent angle and speed-up. It detects misses, pulses a score output, and re-serves after a delay. It sits between the paddle controllers / collision inputs and the video renderer / score keeper.

Parameters:
FIELD_W, 64, field width in pixels (power of 2 not required, >=16)
FIELD_H, 48, field height in pixels
FRAC_W, 4, fractional bits of position/velocity
PADDLE_H, 8, paddle height in pixels (multiple of 4)
PADDLE_L_X, 2, pixel column of left paddle face
PADDLE_R_X, 61, pixel column of right paddle face
VX_INIT, 16, serve horizontal speed, fixed point (16 = 1.0 px/tick)
VX_STEP, 4, speed added to |vx| per paddle hit
VX_MAX, 48, saturation limit of |vx|
SERVE_DELAY, 30, ticks spent waiting at centre before serve

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
tick  in  1  one-cycle frame step enable
start  in  1  leave IDLE and begin first serve
paddle_l_y  in  clog2(FIELD_H)  top pixel row of left paddle
paddle_r_y  in  clog2(FIELD_H)  top pixel row of right paddle
ball_x  out  clog2(FIELD_W)  integer pixel column of ball
ball_y  out  clog2(FIELD_H)  integer pixel row of ball
dir_x  out  1  1 = moving right (+x)
dir_y  out  1  1 = moving down (+y)
score_l  out  1  one-cycle pulse, left player scored (ball passed right edge)
score_r  out  1  one-cycle pulse, right player scored
in_play  out  1  high in MOVING state
state_o  out  2  current state (IDLE=0, WAIT=1, MOVING=2, SCORED=3)

Behaviour:
- Reset (async, any time, including mid-move): state IDLE; position = centre (FIELD_W/2, FIELD_H/2) << FRAC_W; |vx| = VX_INIT; |vy| = 0; dir_x = 0, dir_y = 0; score pulses 0; LFSR = 8'hA5.
- LFSR: 8-bit Fibonacci, taps x^8+x^6+x^5+x^4+1. Advances every clk regardless of tick.
- IDLE: ball held at centre. `start` moves to WAIT and clears the wait counter. Hold at centre.
- WAIT: counts ticks. When the count reaches SERVE_DELAY, serve takes effect in the same cycle as that tick, and the state moves to MOVING:
  - |vx| = VX_INIT
  - |vy| = (lfsr[1:0]+1)*4
  - dir_y = lfsr[2]
  - dir_x = lfsr[3] on the first serve, otherwise toward the player who conceded.
- MOVING, on tick only. Compute in signed width clog2(max)+FRAC_W+2; no wrap permitted.
  - nx = x ± |vx|, ny = y ± |vy|.
  - Wall: if ny < 0, then y = 0 and dir_y = 1. If ny > (FIELD_H-1)<<FRAC_W, then y = that max and dir_y = 0.
  - Left paddle, checked when dir_x = 0 and int(nx) <= PADDLE_L_X.
    - Hit condition: paddle_l_y <= int(y) <= paddle_l_y+PADDLE_H-1.
    - On hit: x = (PADDLE_L_X+1)<<FRAC_W; dir_x = 1; |vx| = min(|vx|+VX_STEP, VX_MAX).
    - Zone by off = int(y) - paddle_l_y: off < PADDLE_H/4 gives dir_y = 0, |vy| = 12. off >= 3*PADDLE_H/4 gives dir_y = 1, |vy| = 12. Otherwise vy is unchanged.
    - Miss: if nx < 0, then score_r pulses and the state moves to SCORED.
  - Right paddle: mirror of the left paddle at PADDLE_R_X, using int(nx) >= PADDLE_R_X.
    - Hit: x = (PADDLE_R_X-1)<<FRAC_W.
    - Miss when nx > (FIELD_W-1)<<FRAC_W: score_l pulses.
  - Simultaneous wall and paddle in the same tick: both corrections apply. Paddle zone selection uses the pre-update int(y).
- SCORED: next cycle, ball returns to centre, the wait counter is cleared, and the state moves to WAIT. Score pulses are exactly one cycle. In every other state score pulses are 0.
- No state change occurs on cycles without tick, except IDLE→WAIT on `start`, the SCORED→WAIT transition, and reset.
- Outputs are registered; ball_x and ball_y equal the integer bits of the position registers.

Test Plan:
- Reset mid-MOVING, then release → ball_x=32, ball_y=24, state_o=0, in_play=0, no score pulse.
- start, then 30 ticks → serve on the 30th tick. |vx|=16; after 1 more tick ball_x=31 or 33 according to lfsr[3]; ball_y moves by 0.25–1.0 px.
- Force y = 0.5 px (8), dir_y=0, |vy|=12, then tick → ball_y=0, dir_y=1 (clamp, not wrap).
- Ball moving left at x=3.0, |vx|=16, paddle_l_y=20, ball_y=21, then tick → ball_x=3, dir_x=1, |vx|=20, dir_y=0, |vy|=12. Repeated hits saturate |vx| at 48.
- Same approach with paddle_l_y=40 (miss) → ball continues left; on crossing x<0, score_r is high exactly 1 cycle. Next cycle WAIT, ball at centre. After 30 ticks, served with dir_x=0.
- Corner: ball at (3.0, 0.25), moving up-left, paddle_l_y=0 → single tick gives ball_y=0, dir_y=0 (top zone), dir_x=1.
